// File: rtl/data_mem_arbiter.sv
// Two-requester arbiter that serialises byte/halfword/word loads and stores onto
// a single byte-wide data memory port, one byte per cycle, little-endian.
module data_mem_arbiter #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [1:0]        size0,
    input  logic [1:0]        size1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [31:0]       wdata0,
    input  logic [31:0]       wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic [31:0]       rdata0,
    output logic [31:0]       rdata1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    state_t      state, state_nxt;
    logic        owner;
    logic        last_gnt;
    logic        we_lat;
    logic [1:0]  size_lat;
    logic [31:0] wdata_lat;
    logic [31:0] rbuf;
    logic [1:0]  idx;
    logic        xfer_last;
    logic [31:0] load_word;

    function automatic logic [1:0] last_index(input logic [1:0] size);
        case (size)
            2'b00:   return 2'd0;
            2'b01:   return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

    function automatic logic [7:0] get_byte(input logic [31:0] word, input logic [1:0] sel);
        return word[{sel, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] put_byte(input logic [31:0] word, input logic [1:0] sel,
                                             input logic [7:0] data);
        logic [31:0] w;
        w = word;
        w[{sel, 3'b000} +: 8] = data;
        return w;
    endfunction

    // Ties go to whichever requester was not served last.
    always_comb begin
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        done0     = 1'b0;
        done1     = 1'b0;
        state_nxt = state;
        xfer_last = (state == XFER) && (idx == last_index(size_lat));
        load_word = put_byte(rbuf, idx, mem_rdata);
        mem_we    = (state == XFER) && we_lat;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                gnt0 = req0 && (!req1 || last_gnt);
                gnt1 = req1 && (!req0 || !last_gnt);
                if (gnt0 || gnt1) state_nxt = XFER;
            end
            XFER: begin
                if (xfer_last) state_nxt = DONE;
            end
            DONE: begin
                done0     = !owner;
                done1     = owner;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            owner     <= 1'b0;
            last_gnt  <= 1'b1;
            we_lat    <= 1'b0;
            size_lat  <= 2'b00;
            wdata_lat <= '0;
            rbuf      <= '0;
            idx       <= 2'd0;
            rdata0    <= '0;
            rdata1    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state <= state_nxt;
            if (gnt0 || gnt1) begin
                owner     <= gnt1;
                last_gnt  <= gnt1;
                we_lat    <= gnt1 ? we1 : we0;
                size_lat  <= gnt1 ? size1 : size0;
                wdata_lat <= gnt1 ? wdata1 : wdata0;
                mem_addr  <= gnt1 ? addr1 : addr0;
                mem_wdata <= gnt1 ? wdata1[7:0] : wdata0[7:0];
                rbuf      <= '0;
                idx       <= 2'd0;
            end else if (state == XFER) begin
                rbuf <= load_word;
                if (xfer_last) begin
                    // Publish only the completed word so rdata never shows partial loads.
                    if (!we_lat) begin
                        if (owner) rdata1 <= load_word;
                        else       rdata0 <= load_word;
                    end
                end else begin
                    idx       <= idx + 2'd1;
                    mem_addr  <= mem_addr + ADDR_W'(1);
                    mem_wdata <= get_byte(wdata_lat, idx + 2'd1);
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Randomised and directed bench for data_mem_arbiter against a transaction-level
// model of arbitration, byte sequencing, latency and memory contents.
module tb_data_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, req1, we0, we1;
    logic [1:0]  size0, size1;
    logic [7:0]  addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic        gnt0, gnt1, done0, done1;
    logic [31:0] rdata0, rdata1;
    logic [7:0]  mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        busy;

    always #5 clk = ~clk;

    data_mem_arbiter #(.ADDR_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .size0(size0), .size1(size1), .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .rdata0(rdata0), .rdata1(rdata1),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    function automatic logic [7:0] pat(input int i);
        return 8'((i * 37) ^ 90);
    endfunction

    // Byte-wide data memory attached to the arbiter
    logic [7:0] dmem [256];
    logic       fill = 1'b1;
    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < 256; i++) dmem[i] <= pat(i);
        end else if (mem_we) begin
            dmem[mem_addr] <= mem_wdata;
        end
    end
    assign mem_rdata = dmem[mem_addr];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model state
    logic [7:0]  ref_mem [256];
    int          cyc = 0;
    int          free_at = 0;
    logic        last_r = 1'b1;
    logic        pend[2], keep[2], pwe[2];
    logic [1:0]  psize[2];
    logic [7:0]  paddr[2];
    logic [31:0] pwdata[2];
    logic [31:0] exp_rdata[2];
    int          gcyc[2];
    int          obs_gnt_cyc[2], obs_done_cyc[2];
    int          grant_log[$];
    bit          rand_en = 1'b0;
    bit          tr_valid = 1'b0;
    int          tr_t, tr_n;
    logic        tr_owner, tr_we;
    logic [7:0]  tr_addr;
    logic [31:0] tr_wdata, tr_load;

    function automatic int nbytes(input logic [1:0] s);
        return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
    endfunction

    task automatic post(input int r, input logic w, input logic [1:0] s,
                        input logic [7:0] a, input logic [31:0] d);
        pend[r]   = 1'b1;
        pwe[r]    = w;
        psize[r]  = s;
        paddr[r]  = a;
        pwdata[r] = d;
    endtask

    task automatic step();
        logic       eg[2];
        logic       exp_done[2];
        logic       exp_we, exp_busy;
        int         k;
        logic [7:0] a, b;
        @(negedge clk);
        req0   = pend[0];
        we0    = pend[0] ? pwe[0]    : 1'($urandom);
        size0  = pend[0] ? psize[0]  : 2'($urandom);
        addr0  = pend[0] ? paddr[0]  : 8'($urandom);
        wdata0 = pend[0] ? pwdata[0] : $urandom;
        req1   = pend[1];
        we1    = pend[1] ? pwe[1]    : 1'($urandom);
        size1  = pend[1] ? psize[1]  : 2'($urandom);
        addr1  = pend[1] ? paddr[1]  : 8'($urandom);
        wdata1 = pend[1] ? pwdata[1] : $urandom;
        #1;
        cyc++;
        eg = '{1'b0, 1'b0};
        if (cyc >= free_at) begin
            if (pend[0] && (!pend[1] || last_r)) eg[0] = 1'b1;
            else if (pend[1])                    eg[1] = 1'b1;
        end
        check_val("gnt0", gnt0, eg[0]);
        check_val("gnt1", gnt1, eg[1]);
        if (gnt0)  obs_gnt_cyc[0]  = cyc;
        if (gnt1)  obs_gnt_cyc[1]  = cyc;
        if (done0) obs_done_cyc[0] = cyc;
        if (done1) obs_done_cyc[1] = cyc;
        for (int r = 0; r < 2; r++) begin
            if (eg[r]) begin
                tr_valid = 1'b1;
                tr_t     = cyc;
                tr_n     = nbytes(psize[r]);
                tr_owner = r[0];
                tr_we    = pwe[r];
                tr_addr  = paddr[r];
                tr_wdata = pwdata[r];
                tr_load  = '0;
                for (int j = 0; j < tr_n; j++)
                    tr_load |= 32'(ref_mem[8'(paddr[r] + j)]) << (8 * j);
                free_at = cyc + tr_n + 2;
                last_r  = r[0];
                gcyc[r] = cyc;
                pend[r] = keep[r];
                grant_log.push_back(r);
            end
        end
        exp_we   = 1'b0;
        exp_busy = 1'b0;
        exp_done = '{1'b0, 1'b0};
        if (tr_valid && cyc > tr_t && cyc <= tr_t + tr_n + 1) begin
            exp_busy = 1'b1;
            if (cyc <= tr_t + tr_n) begin
                k      = cyc - tr_t - 1;
                a      = tr_addr + 8'(k);
                exp_we = tr_we;
                check_val("mem_addr", mem_addr, a);
                if (tr_we) begin
                    b = tr_wdata[8*k +: 8];
                    check_val("mem_wdata", mem_wdata, b);
                    ref_mem[a] = b;
                end
            end else begin
                exp_done[tr_owner] = 1'b1;
                if (!tr_we) exp_rdata[tr_owner] = tr_load;
            end
        end
        check_val("done0", done0, exp_done[0]);
        check_val("done1", done1, exp_done[1]);
        check_val("mem_we", mem_we, exp_we);
        check_val("busy", busy, exp_busy);
        check_val("rdata0", rdata0, exp_rdata[0]);
        check_val("rdata1", rdata1, exp_rdata[1]);
        for (int r = 0; r < 2; r++) begin
            if (rand_en && !pend[r] && cyc > gcyc[r] && $urandom_range(0, 2) == 0)
                post(r, 1'($urandom), 2'($urandom), 8'($urandom), $urandom);
        end
    endtask

    task automatic run_quiet(input int max_cyc);
        int n;
        n = 0;
        while ((pend[0] || pend[1] || cyc < free_at) && n < max_cyc) begin
            step();
            n++;
        end
        if (n >= max_cyc) check_val("quiet_timeout", 1, 0);
    endtask

    initial begin
        pend = '{1'b0, 1'b0}; keep = '{1'b0, 1'b0}; pwe = '{1'b0, 1'b0};
        psize = '{2'b00, 2'b00}; paddr = '{8'h0, 8'h0}; pwdata = '{32'h0, 32'h0};
        exp_rdata = '{32'h0, 32'h0}; gcyc = '{0, 0};
        obs_gnt_cyc = '{0, 0}; obs_done_cyc = '{0, 0};
        rst_n = 1'b0;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0; size0 = 0; size1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        fill = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = pat(i);
        #1;
        check_val("rst_gnt0", gnt0, 0);
        check_val("rst_gnt1", gnt1, 0);
        check_val("rst_done0", done0, 0);
        check_val("rst_done1", done1, 0);
        check_val("rst_rdata0", rdata0, 0);
        check_val("rst_rdata1", rdata1, 0);
        check_val("rst_mem_addr", mem_addr, 0);
        check_val("rst_mem_we", mem_we, 0);
        check_val("rst_mem_wdata", mem_wdata, 0);
        check_val("rst_busy", busy, 0);

        // Both requesting from reset: round-robin order 0,1,0
        post(0, 1'b0, 2'b00, 8'h80, 32'h0);
        post(1, 1'b0, 2'b00, 8'h81, 32'h0);
        keep = '{1'b1, 1'b1};
        rst_n = 1'b1;
        repeat (12) step();
        keep = '{1'b0, 1'b0};
        run_quiet(50);
        check_val("tie_count_ok", grant_log.size() >= 3, 1);
        check_val("tie_first",  grant_log.size() > 0 ? grant_log[0] : 99, 0);
        check_val("tie_second", grant_log.size() > 1 ? grant_log[1] : 99, 1);
        check_val("tie_third",  grant_log.size() > 2 ? grant_log[2] : 99, 0);

        // Word store then load
        post(0, 1'b1, 2'b10, 8'h10, 32'hA1B2C3D4);
        run_quiet(30);
        check_val("word_store_latency", obs_done_cyc[0] - obs_gnt_cyc[0], 5);
        check_val("word_b0", dmem[8'h10], 8'hD4);
        check_val("word_b1", dmem[8'h11], 8'hC3);
        check_val("word_b2", dmem[8'h12], 8'hB2);
        check_val("word_b3", dmem[8'h13], 8'hA1);
        post(0, 1'b0, 2'b10, 8'h10, 32'h0);
        run_quiet(30);
        check_val("word_load", rdata0, 32'hA1B2C3D4);

        // Byte load
        post(0, 1'b1, 2'b00, 8'h20, 32'h0000009C);
        run_quiet(30);
        post(0, 1'b0, 2'b00, 8'h20, 32'h0);
        run_quiet(30);
        check_val("byte_load", rdata0, 32'h0000009C);
        check_val("byte_load_latency", obs_done_cyc[0] - obs_gnt_cyc[0], 2);

        // Halfword load wrapping 0xFF -> 0x00
        post(1, 1'b1, 2'b00, 8'hFF, 32'h34);
        run_quiet(30);
        post(1, 1'b1, 2'b00, 8'h00, 32'h12);
        run_quiet(30);
        post(1, 1'b0, 2'b01, 8'hFF, 32'h0);
        run_quiet(30);
        check_val("wrap_load", rdata1, 32'h00001234);

        // Request arriving during another transfer waits for IDLE
        post(0, 1'b0, 2'b10, 8'h30, 32'h0);
        step();
        post(1, 1'b0, 2'b00, 8'h31, 32'h0);
        run_quiet(30);
        check_val("late_req_gap", obs_gnt_cyc[1] - obs_done_cyc[0], 1);

        // Reset in the third cycle of a word store
        post(0, 1'b1, 2'b10, 8'h40, 32'h11223344);
        step();
        step();
        step();
        @(posedge clk);
        #2;
        check_val("pre_rst_mem_we", mem_we, 1);
        rst_n = 1'b0;
        #1;
        check_val("midrst_mem_we", mem_we, 0);
        check_val("midrst_busy", busy, 0);
        check_val("midrst_done0", done0, 0);
        check_val("midrst_rdata0", rdata0, 0);
        tr_valid = 1'b0; free_at = 0; last_r = 1'b1;
        exp_rdata = '{32'h0, 32'h0}; pend = '{1'b0, 1'b0};
        @(negedge clk);
        rst_n = 1'b1;
        check_val("midrst_b0", dmem[8'h40], 8'h44);
        check_val("midrst_b1", dmem[8'h41], 8'h33);
        check_val("midrst_b2", dmem[8'h42], pat(8'h42));
        check_val("midrst_b3", dmem[8'h43], pat(8'h43));
        repeat (4) step();

        // Random traffic from both requesters
        rand_en = 1'b1;
        repeat (1500) step();
        rand_en = 1'b0;
        run_quiet(60);
        for (int i = 0; i < 256; i++) check_val("mem_contents", dmem[i], ref_mem[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
